// File: rtl/nibble_alu_ctrl_if.sv
// nibble_alu_ctrl_if
//   Bundles the host handshake (start/sub/a/b in, busy/done/result/carry_out/
//   overflow out) and the external 4-bit adder slice port (adder_a/b/cin out,
//   adder_s/c4 in) of nibble_alu_ctrl.
//   slave  : the sequencer itself.
//   master : the surrounding system (host registers plus the adder slice).
//   NIBBLES sets the operand width, W = 4*NIBBLES.
interface nibble_alu_ctrl_if #(
    parameter int NIBBLES = 2
);
    localparam int W = 4 * NIBBLES;

    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;
    logic [3:0]   adder_a;
    logic [3:0]   adder_b;
    logic         adder_cin;
    logic [3:0]   adder_s;
    logic         adder_c4;

    modport slave (
        input  start, sub, a, b, adder_s, adder_c4,
        output busy, done, result, carry_out, overflow,
               adder_a, adder_b, adder_cin
    );

    modport master (
        output start, sub, a, b, adder_s, adder_c4,
        input  busy, done, result, carry_out, overflow,
               adder_a, adder_b, adder_cin
    );
endinterface

// File: rtl/nibble_alu_ctrl.sv
// nibble_alu_ctrl
//   Multi-nibble add/subtract sequencer that time-shares one external 4-bit
//   adder slice, one nibble per clock, LSB first, with a carry flip-flop
//   chaining the nibbles.
//   Ports:
//     CLK  - system clock, rising edge
//     CLR  - asynchronous active-high reset
//     bus  - nibble_alu_ctrl_if.slave: start/sub/a/b request, busy/done
//            handshake, registered result/carry_out/overflow, and the
//            adder slice port (adder_a/b/cin out, adder_s/c4 in).
//   Optional feature: define NIBBLE_ALU_CTRL_OVERFLOW_EN to build the signed
//   overflow flag; otherwise overflow is tied low.
module nibble_alu_ctrl #(
    parameter int NIBBLES = 2
) (
    input  logic             CLK,
    input  logic             CLR,
    nibble_alu_ctrl_if.slave bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic          sub_reg;
    logic          carry_reg;
    logic [IW-1:0] idx;
    logic [W-1:0]  work;
    logic [W-1:0]  work_next;
    logic [W-1:0]  result_r;
    logic          carry_out_r;
    logic          busy_r;
    logic          done_r;
    logic [IW+1:0] bit_base;
    logic          last_nibble;

    assign bit_base    = {idx, 2'b00};
    assign last_nibble = (state == RUN) && (idx == LAST_IDX);

    // Slice inputs are live only while running so the shared adder sees zeros otherwise.
    always_comb begin
        bus.adder_a   = '0;
        bus.adder_b   = '0;
        bus.adder_cin = 1'b0;
        if (state == RUN) begin
            bus.adder_a   = a_reg[bit_base +: 4];
            bus.adder_b   = sub_reg ? ~b_reg[bit_base +: 4] : b_reg[bit_base +: 4];
            bus.adder_cin = carry_reg;
        end
    end

    // Work with the current nibble merged in, so the final edge can publish it directly.
    always_comb begin
        work_next                = work;
        work_next[bit_base +: 4] = bus.adder_s;
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state       <= IDLE;
            a_reg       <= '0;
            b_reg       <= '0;
            sub_reg     <= 1'b0;
            carry_reg   <= 1'b0;
            idx         <= '0;
            work        <= '0;
            result_r    <= '0;
            carry_out_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        a_reg     <= bus.a;
                        b_reg     <= bus.b;
                        sub_reg   <= bus.sub;
                        carry_reg <= bus.sub;   // the +1 of two's-complement subtract
                        idx       <= '0;
                        busy_r    <= 1'b1;
                        state     <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    work      <= work_next;
                    carry_reg <= bus.adder_c4;
                    idx       <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        result_r    <= work_next;
                        carry_out_r <= bus.adder_c4;
                        busy_r      <= 1'b0;
                        done_r      <= 1'b1;
                        state       <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.result    = result_r;
    assign bus.carry_out = carry_out_r;

`ifdef NIBBLE_ALU_CTRL_OVERFLOW_EN
    logic overflow_r;
    logic b_eff_msb;

    assign b_eff_msb = b_reg[W-1] ^ sub_reg;

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            overflow_r <= 1'b0;
        end else if (last_nibble) begin
            overflow_r <= (a_reg[W-1] == b_eff_msb) && (work_next[W-1] != a_reg[W-1]);
        end
    end

    assign bus.overflow = overflow_r;
`else
    assign bus.overflow = 1'b0;
`endif

endmodule

// File: tb/tb_nibble_alu_ctrl.sv
// tb_nibble_alu_ctrl
//   Scoreboard bench for nibble_alu_ctrl. The driver issues operations
//   (directed plus $urandom) and pushes each accepted one into a queue along
//   with the cycle its done pulse is due. A negedge monitor checks busy, the
//   adder slice port, done timing and held result/carry_out/overflow against
//   an arithmetic model of the operation. The adder slice is modelled here.
//   Honours NIBBLE_ALU_CTRL_OVERFLOW_EN for the overflow expectation.
module tb_nibble_alu_ctrl;
    localparam int N = 2;
    localparam int W = 4 * N;
    localparam longint unsigned MASK = (64'd1 << W) - 64'd1;
`ifdef NIBBLE_ALU_CTRL_OVERFLOW_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    typedef struct {
        bit              sub;
        longint unsigned a;
        longint unsigned b;
        int              exp_cyc;
    } op_t;

    logic CLK = 1'b0;
    logic CLR = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fails = 0;
    op_t  q[$];

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    nibble_alu_ctrl_if #(.NIBBLES(N)) bus ();

    nibble_alu_ctrl #(.NIBBLES(N)) dut (
        .CLK (CLK),
        .CLR (CLR),
        .bus (bus)
    );

    // External 4-bit adder slice.
    assign {bus.adder_c4, bus.adder_s} = 5'(bus.adder_a) + 5'(bus.adder_b) + 5'(bus.adder_cin);

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic longint unsigned beff(input op_t o);
        return o.sub ? (~o.b & MASK) : o.b;
    endfunction

    function automatic longint unsigned full_sum(input op_t o);
        return o.a + beff(o) + longint'(o.sub);
    endfunction

    function automatic longint unsigned exp_res(input op_t o);
        return full_sum(o) & MASK;
    endfunction

    function automatic bit exp_carry(input op_t o);
        return bit'((full_sum(o) >> W) & 64'd1);
    endfunction

    function automatic longint to_signed(input longint unsigned v);
        return (v >= (64'd1 << (W - 1))) ? longint'(v) - (longint'(1) << W) : longint'(v);
    endfunction

    // Signed overflow: the true signed sum does not fit in W bits.
    function automatic bit exp_ovf(input op_t o);
        longint s;
        bit     ovf;
        s   = to_signed(o.a) + to_signed(beff(o)) + longint'(o.sub);
        ovf = (s > (longint'(1) << (W - 1)) - 1) || (s < -(longint'(1) << (W - 1)));
        return ovf & OVF_EN;
    endfunction

    // ---------------- monitor ----------------
    op_t             cur;
    longint unsigned last_res = 0;
    bit              last_c = 1'b0;
    bit              last_o = 1'b0;
    bit              exp_busy;
    longint unsigned ea, eb, ec, lowm, be;
    int              nib;

    always @(negedge CLK) begin
        if (CLR) begin
            q.delete();
            last_res = 0;
            last_c   = 1'b0;
            last_o   = 1'b0;
            chk("rst_busy", bus.busy, 0);
            chk("rst_done", bus.done, 0);
            chk("rst_result", bus.result, 0);
            chk("rst_carry", bus.carry_out, 0);
            chk("rst_ovf", bus.overflow, 0);
            chk("rst_adder_a", bus.adder_a, 0);
            chk("rst_adder_b", bus.adder_b, 0);
            chk("rst_adder_cin", bus.adder_cin, 0);
        end else begin
            if (q.size() > 0 && q[0].exp_cyc <= cyc) begin
                cur = q.pop_front();
                chk("done_pulse", bus.done, 1);
                chk("done_cycle", cyc, cur.exp_cyc);
                last_res = exp_res(cur);
                last_c   = exp_carry(cur);
                last_o   = exp_ovf(cur);
            end else begin
                chk("done_quiet", bus.done, 0);
            end
            chk("result", bus.result, last_res);
            chk("carry_out", bus.carry_out, last_c);
            chk("overflow", bus.overflow, last_o);

            exp_busy = 1'b0;
            ea = 0;
            eb = 0;
            ec = 0;
            foreach (q[i]) begin
                if (cyc >= q[i].exp_cyc - N && cyc < q[i].exp_cyc) begin
                    nib      = cyc - (q[i].exp_cyc - N);
                    be       = beff(q[i]);
                    lowm     = (64'd1 << (4 * nib)) - 64'd1;
                    exp_busy = 1'b1;
                    ea       = (q[i].a >> (4 * nib)) & 64'hF;
                    eb       = (be >> (4 * nib)) & 64'hF;
                    ec       = (((q[i].a & lowm) + (be & lowm) + longint'(q[i].sub)) >> (4 * nib)) & 64'd1;
                end
            end
            chk("busy", bus.busy, exp_busy);
            chk("adder_a", bus.adder_a, ea);
            chk("adder_b", bus.adder_b, eb);
            chk("adder_cin", bus.adder_cin, ec);
        end
    end

    // ---------------- driver ----------------
    task automatic push(input bit s, input longint unsigned a, input longint unsigned b, input int due);
        op_t o;
        o.sub     = s;
        o.a       = a & MASK;
        o.b       = b & MASK;
        o.exp_cyc = due;
        q.push_back(o);
    endtask

    task automatic scramble();
        bus.sub = 1'(($urandom));
        bus.a   = W'($urandom);
        bus.b   = W'($urandom);
    endtask

    // Entered at a negedge with the DUT idle; returns at a negedge, idle again.
    task automatic single(input bit s, input longint unsigned a, input longint unsigned b);
        bus.start = 1'b1;
        bus.sub   = s;
        bus.a     = W'(a);
        bus.b     = W'(b);
        push(s, a, b, cyc + 1 + N);
        @(negedge CLK);
        bus.start = 1'b0;
        scramble();
        repeat (N + 1) @(negedge CLK);
    endtask

    // Start held high through DONE so the second op follows immediately.
    task automatic back_to_back(input bit s1, input longint unsigned a1, input longint unsigned b1,
                                input bit s2, input longint unsigned a2, input longint unsigned b2);
        bus.start = 1'b1;
        bus.sub   = s1;
        bus.a     = W'(a1);
        bus.b     = W'(b1);
        push(s1, a1, b1, cyc + 1 + N);
        push(s2, a2, b2, cyc + 1 + N + N + 1);
        @(negedge CLK);
        bus.sub = s2;
        bus.a   = W'(a2);
        bus.b   = W'(b2);
        repeat (N + 1) @(negedge CLK);
        bus.start = 1'b0;
        scramble();
        repeat (N + 1) @(negedge CLK);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        CLR       = 1'b1;
        repeat (3) @(negedge CLK);
        CLR = 1'b0;
        @(negedge CLK);

        single(1'b0, 64'h3C, 64'h4A);
        single(1'b0, 64'hFF, 64'h01);
        single(1'b1, 64'h50, 64'h20);
        single(1'b1, 64'h20, 64'h50);

        // Start pulsed mid-RUN with other operands must be ignored.
        bus.start = 1'b1;
        bus.sub   = 1'b0;
        bus.a     = W'(64'h0F);
        bus.b     = W'(64'h0E);
        push(1'b0, 64'h0F, 64'h0E, cyc + 1 + N);
        @(negedge CLK);
        bus.sub = 1'b1;
        bus.a   = W'(64'h99);
        bus.b   = W'(64'h77);
        @(negedge CLK);
        bus.start = 1'b0;
        repeat (N) @(negedge CLK);

        // CLR after nibble 0 of an op: everything clears at once, no done.
        bus.start = 1'b1;
        bus.sub   = 1'b0;
        bus.a     = W'(64'h3C);
        bus.b     = W'(64'h4A);
        push(1'b0, 64'h3C, 64'h4A, cyc + 1 + N);
        @(negedge CLK);
        bus.start = 1'b0;
        @(negedge CLK);
        #2 CLR = 1'b1;
        #1;
        chk("clr_busy", bus.busy, 0);
        chk("clr_done", bus.done, 0);
        chk("clr_result", bus.result, 0);
        chk("clr_carry", bus.carry_out, 0);
        chk("clr_ovf", bus.overflow, 0);
        chk("clr_adder_a", bus.adder_a, 0);
        chk("clr_adder_b", bus.adder_b, 0);
        chk("clr_adder_cin", bus.adder_cin, 0);
        repeat (2) @(negedge CLK);
        CLR = 1'b0;
        @(negedge CLK);
        single(1'b0, 64'h12, 64'h34);

        back_to_back(1'b0, 64'h11, 64'h22, 1'b1, 64'h80, 64'h01);

        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 3) == 0)
                back_to_back(1'(($urandom)), longint'($urandom), longint'($urandom),
                             1'(($urandom)), longint'($urandom), longint'($urandom));
            else
                single(1'(($urandom)), longint'($urandom), longint'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge CLK);
        end

        repeat (4) @(negedge CLK);
        chk("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/nibble_alu_ctrl.md
# nibble_alu_ctrl

Sequencer that performs multi-nibble add/subtract by time-sharing a single external 4-bit adder slice (A, B, C0 in; S, C4 out), one nibble per clock, LSB first. It sits between the SAP accumulator/B registers and the adder chip, replacing a cascaded adder chain with one slice plus a carry flip-flop. The outside world sees a start/busy/done handshake and a registered result, carry and optional overflow.

## Interface
- NIBBLES, default 2: operand width in nibbles (W = 4*NIBBLES bits); legal range 1..8.
- CLK  in  1  system clock; all state changes on rising edge.
- CLR  in  1  asynchronous, active-high reset.
- start  in  1  request an operation; sampled only in IDLE or DONE.
- sub  in  1  0 = A+B, 1 = A-B; sampled with start.
- a  in  W  operand A; sampled with start.
- b  in  W  operand B; sampled with start.
- busy  out  1  high while nibbles are being processed (RUN).
- done  out  1  one-cycle pulse: result/carry_out/overflow just updated.
- result  out  W  last completed sum/difference; holds until next completion.
- carry_out  out  1  final C4 of last op (for sub: 1 = no borrow).
- overflow  out  1  signed overflow of last op (see Configuration).
- adder_a  out  4  nibble of A to slice.
- adder_b  out  4  nibble of B (inverted when sub) to slice.
- adder_cin  out  1  carry into slice.
- adder_s  in  4  slice sum, combinational from adder_a/b/cin.
- adder_c4  in  1  slice carry out.

## Operation
- States: IDLE, RUN, DONE. Reset state IDLE.
- IDLE/DONE, start=1: latch a, b, sub into operand regs; idx <- 0; carry reg <- sub; go RUN.
- IDLE, start=0: stay. DONE, start=0: go IDLE.
- RUN, nibble idx: adder_a = A[4idx+3:4idx]; adder_b = B nibble, bitwise inverted if sub; adder_cin = carry reg.
- RUN edge: work[4idx+3:4idx] <- adder_s; carry reg <- adder_c4; idx <- idx+1.
- RUN edge with idx = NIBBLES-1: additionally result <- completed work, carry_out <- adder_c4, overflow updated; go DONE.
- Subtraction = A + ~B + 1, modulo 2^W; borrow = ~carry_out.
- start while RUN: ignored (no queueing); operands held from latch.
- adder_a, adder_b, adder_cin driven 0 in IDLE and DONE.
- CLR asserted at any time, including mid-RUN: immediately IDLE; busy, done, result, carry_out, overflow, idx, carry reg, work, operand regs all 0; partial operation discarded, no done pulse.

## Timing
- Start accepted at edge t0; RUN occupies cycles between t0 and tNIBBLES; busy high exactly NIBBLES cycles.
- result/carry_out/overflow change only at edge tNIBBLES; done high for the single cycle following that edge.
- Start→done latency: NIBBLES+1 edges counting the accept edge as 1 when done is read at edge tNIBBLES+1.
- Back-to-back: start held high in DONE begins next op; throughput one op per NIBBLES+1 cycles.
- Adder is combinational: adder_s/adder_c4 must settle within the same cycle they are driven.
- Reset values: busy 0, done 0, result 0, carry_out 0, overflow 0, adder_* 0.

## Configuration
- Macro NIBBLE_ALU_CTRL_OVERFLOW_EN.
- Defined: overflow <- (A[W-1] == Beff[W-1]) && (sum[W-1] != A[W-1]), Beff = B or ~B per sub, evaluated at final RUN edge.
- Undefined: overflow tied 0; no overflow logic synthesized.

## Test plan
- NIBBLES=2, add 0x3C+0x4A -> busy 2 cycles, done pulse, result 0x86, carry_out 0, overflow 1 (0 if macro undefined).
- Add 0xFF+0x01 -> result 0x00, carry_out 1, overflow 0; adder_cin sequence 0,1 observed on slice port.
- Sub 0x50-0x20 -> result 0x30, carry_out 1; sub 0x20-0x50 -> result 0xD0, carry_out 0, overflow 0.
- Start pulsed during RUN with different operands -> ignored; result of first op unchanged, exactly one done.
- CLR asserted mid-RUN after nibble 0 -> all outputs 0 immediately, state IDLE, no done; new op afterward completes correctly.
- Start held high across DONE for two ops (0x11+0x22, then 0x80-0x01) -> results 0x33 then 0x7F (carry 1, overflow 1), done spaced 3 cycles apart.
